// File: rtl/fb_ddram_arbiter.sv
// rtl/fb_ddram_arbiter.sv - DDRAM arbiter: FIFO-buffered posted writes (A) vs req/ack client (B)
// Optional FB_ARB_STATS_EN adds A_DROPS and MAX_LEVEL statistics outputs.
module fb_ddram_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int HIGH_WM    = 6
) (
  input  logic        CLK_VIDEO,
  input  logic        reset,
  input  logic        A_WE,
  input  logic [28:0] A_ADDR,
  input  logic [63:0] A_DIN,
  input  logic [7:0]  A_BE,
  output logic        A_FULL,
  output logic        A_OVF,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [28:0] B_ADDR,
  input  logic [63:0] B_DIN,
  input  logic [7:0]  B_BE,
  output logic [63:0] B_DOUT,
  output logic        B_ACK,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic        DDRAM_RD,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0] A_DROPS,
  output logic [5:0]  MAX_LEVEL
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 29 + 8 + 64;

  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_RD_B, S_RD_WAIT} state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  lvl_q;
  logic           ovf_q;
  logic           we_q, we_d, rd_q, rd_d, ack_q, ack_d, rr_b_q, rr_b_d;
  logic [28:0]    addr_q, addr_d;
  logic [63:0]    din_q, din_d, dout_q, dout_d;
  logic [7:0]     be_q, be_d;
  logic           full, pop, push, drop, a_pend, b_pend, grant_a, grant_b;
  logic [EW-1:0]  head;

  assign full   = (lvl_q == LW'(FIFO_DEPTH));
  assign pop    = (state_q == S_WR_A) && !DDRAM_BUSY;
  assign push   = A_WE && (!full || pop);
  assign drop   = A_WE && full && !pop;
  assign head   = mem_q[rd_ptr_q];
  assign a_pend = (lvl_q != '0);
  // B_REQ is still high during the ack cycle; it must not look like a new request.
  assign b_pend = B_REQ && !ack_q;

  always_ff @(posedge CLK_VIDEO) begin
    if (push) mem_q[wr_ptr_q] <= {A_ADDR, A_BE, A_DIN};
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      lvl_q <= lvl_q + LW'(1);
      else if (pop && !push) lvl_q <= lvl_q - LW'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      rr_b_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      rr_b_q  <= rr_b_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      be_q    <= be_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    rd_d    = rd_q;
    ack_d   = 1'b0;
    rr_b_d  = rr_b_q;
    addr_d  = addr_q;
    din_d   = din_q;
    be_d    = be_q;
    dout_d  = dout_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lvl_q >= LW'(HIGH_WM))   grant_a = 1'b1;
        else if (a_pend && b_pend) begin
          grant_a = rr_b_q;
          grant_b = !rr_b_q;
        end
        else if (a_pend)             grant_a = 1'b1;
        else if (b_pend)             grant_b = 1'b1;
        if (grant_a) begin
          {addr_d, be_d, din_d} = head;
          we_d    = 1'b1;
          state_d = S_WR_A;
        end else if (grant_b) begin
          addr_d = B_ADDR;
          din_d  = B_DIN;
          be_d   = B_BE;
          if (B_WE) begin
            we_d    = 1'b1;
            state_d = S_WR_B;
          end else begin
            rd_d    = 1'b1;
            state_d = S_RD_B;
          end
        end
      end
      S_WR_A: if (!DDRAM_BUSY) begin
        we_d    = 1'b0;
        rr_b_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_WR_B: if (!DDRAM_BUSY) begin
        we_d    = 1'b0;
        ack_d   = 1'b1;
        rr_b_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_B: if (!DDRAM_BUSY) begin
        rd_d    = 1'b0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (DDRAM_DOUT_READY) begin
        dout_d  = DDRAM_DOUT;
        ack_d   = 1'b1;
        rr_b_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        we_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign A_FULL         = full;
  assign A_OVF          = ovf_q;
  assign B_ACK          = ack_q;
  assign B_DOUT         = dout_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_RD       = rd_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] drops_q;
  logic [5:0]  max_lvl_q;

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      drops_q   <= '0;
      max_lvl_q <= '0;
    end else begin
      if (drop && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
      if (6'(lvl_q) > max_lvl_q) max_lvl_q <= 6'(lvl_q);
    end
  end

  assign A_DROPS   = drops_q;
  assign MAX_LEVEL = max_lvl_q;
`endif

endmodule

// File: tb/tb_fb_ddram_arbiter.sv
// tb/tb_fb_ddram_arbiter.sv - directed self-checking bench for fb_ddram_arbiter
module tb_fb_ddram_arbiter;

  logic        CLK_VIDEO = 1'b0;
  logic        reset = 1'b1;
  logic        A_WE = 1'b0;
  logic [28:0] A_ADDR = '0;
  logic [63:0] A_DIN = '0;
  logic [7:0]  A_BE = '0;
  logic        A_FULL, A_OVF;
  logic        B_REQ = 1'b0;
  logic        B_WE = 1'b0;
  logic [28:0] B_ADDR = '0;
  logic [63:0] B_DIN = '0;
  logic [7:0]  B_BE = '0;
  logic [63:0] B_DOUT;
  logic        B_ACK;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE, DDRAM_RD;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;

  fb_ddram_arbiter #(.FIFO_DEPTH(8), .HIGH_WM(6)) dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset),
    .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BE(A_BE),
    .A_FULL(A_FULL), .A_OVF(A_OVF),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_BE(B_BE),
    .B_DOUT(B_DOUT), .B_ACK(B_ACK),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  typedef struct {
    logic        we;
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } cmd_t;

  cmd_t cmd_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rd_cycles = 0;
  int   ack_cnt = 0;
  bit   both_seen = 1'b0;

  // Negedge monitor: a command seen here with BUSY low is accepted at the next posedge.
  always @(negedge CLK_VIDEO) begin
    if (DDRAM_WE && DDRAM_RD) both_seen = 1'b1;
    if ((DDRAM_WE || DDRAM_RD) && !DDRAM_BUSY)
      cmd_q.push_back('{we: DDRAM_WE, addr: DDRAM_ADDR, din: DDRAM_DIN, be: DDRAM_BE});
    if (DDRAM_RD) rd_cycles++;
    if (B_ACK) ack_cnt++;
  end

  task automatic step();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (A_FULL !== 1'b0) begin n_fail++; $display("FAIL rst_a_full: got %b expected 0", A_FULL); end
    n_checks++; if (A_OVF !== 1'b0) begin n_fail++; $display("FAIL rst_a_ovf: got %b expected 0", A_OVF); end
    n_checks++; if (B_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_b_ack: got %b expected 0", B_ACK); end
    n_checks++; if (B_DOUT !== 64'h0) begin n_fail++; $display("FAIL rst_b_dout: got %h expected 0", B_DOUT); end
    n_checks++; if (DDRAM_WE !== 1'b0 || DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL rst_cmd: got we=%b rd=%b expected 0/0", DDRAM_WE, DDRAM_RD); end
    n_checks++; if (DDRAM_BURSTCNT !== 8'd1) begin n_fail++; $display("FAIL burstcnt: got %h expected 01", DDRAM_BURSTCNT); end
    reset = 1'b0;
    repeat (3) step();
    n_checks++; if (DDRAM_WE !== 1'b0 || DDRAM_RD !== 1'b0) begin n_fail++; $display("FAIL idle_cmd: got we=%b rd=%b expected 0/0", DDRAM_WE, DDRAM_RD); end
  endtask

  task automatic test_a_writes();
    logic [28:0] ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    cmd_q.delete();
    A_WE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A_ADDR = 29'h10 + 29'(i);
      A_DIN  = 64'hA5A5_0000_0000_0000 + 64'(i);
      A_BE   = 8'hF0 + 8'(i);
      step();
    end
    A_WE = 1'b0;
    for (int i = 0; i < 30 && cmd_q.size() < 3; i++) step();
    repeat (5) step();
    n_checks++; if (cmd_q.size() != 3) begin n_fail++; $display("FAIL a_write_count: got %0d expected 3", cmd_q.size()); end
    for (int i = 0; i < cmd_q.size() && i < 3; i++) begin
      ea = 29'h10 + 29'(i);
      ed = 64'hA5A5_0000_0000_0000 + 64'(i);
      eb = 8'hF0 + 8'(i);
      n_checks++;
      if (cmd_q[i].we !== 1'b1 || cmd_q[i].addr !== ea || cmd_q[i].din !== ed || cmd_q[i].be !== eb) begin
        n_fail++;
        $display("FAIL a_write[%0d]: got we=%b %h/%h/%h expected 1 %h/%h/%h", i, cmd_q[i].we, cmd_q[i].addr, cmd_q[i].din, cmd_q[i].be, ea, ed, eb);
      end
    end
    n_checks++; if (A_OVF !== 1'b0 || A_FULL !== 1'b0) begin n_fail++; $display("FAIL a_write_flags: got ovf=%b full=%b expected 0/0", A_OVF, A_FULL); end
  endtask

  task automatic test_b_read();
    cmd_q.delete();
    rd_cycles = 0;
    ack_cnt = 0;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 29'h100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_q.size() > 0) break;
    end
    n_checks++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL b_rd_issue: got %0d commands expected 1", cmd_q.size()); end
    repeat (4) step();
    DDRAM_DOUT_READY = 1'b1;
    DDRAM_DOUT = 64'hDEADBEEF_00C0FFEE;
    step();
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT = 64'h0;
    n_checks++; if (B_ACK !== 1'b1) begin n_fail++; $display("FAIL b_rd_ack: got %b expected 1", B_ACK); end
    n_checks++; if (B_DOUT !== 64'hDEADBEEF_00C0FFEE) begin n_fail++; $display("FAIL b_rd_dout: got %h expected deadbeef00c0ffee", B_DOUT); end
    B_REQ = 1'b0;
    step();
    n_checks++; if (B_ACK !== 1'b0) begin n_fail++; $display("FAIL b_rd_ack_pulse: got %b expected 0", B_ACK); end
    repeat (5) step();
    n_checks++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL b_rd_total: got %0d commands expected 1", cmd_q.size()); end
    if (cmd_q.size() > 0) begin
      n_checks++; if (cmd_q[0].we !== 1'b0 || cmd_q[0].addr !== 29'h100) begin n_fail++; $display("FAIL b_rd_cmd: got we=%b addr=%h expected 0 100", cmd_q[0].we, cmd_q[0].addr); end
    end
    n_checks++; if (rd_cycles != 1) begin n_fail++; $display("FAIL b_rd_pulse: got %0d RD cycles expected 1", rd_cycles); end
    n_checks++; if (ack_cnt != 1) begin n_fail++; $display("FAIL b_rd_ack_count: got %0d expected 1", ack_cnt); end
  endtask

  task automatic test_round_robin();
    logic [28:0] ea [5];
    logic [63:0] ed [5];
    cmd_q.delete();
    A_WE = 1'b1; A_ADDR = 29'h1FF; A_DIN = 64'h1; A_BE = 8'hFF;
    step();
    A_WE = 1'b0;
    for (int i = 0; i < 20 && cmd_q.size() < 1; i++) step();
    repeat (2) step();
    cmd_q.delete();
    A_WE = 1'b1; A_ADDR = 29'h200; A_DIN = 64'hA0;
    step();
    fork
      begin
        A_ADDR = 29'h201; A_DIN = 64'hA1; step();
        A_ADDR = 29'h202; A_DIN = 64'hA2; step();
        A_WE = 1'b0;
      end
      begin
        B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 29'h300; B_DIN = 64'hB0; B_BE = 8'h3C;
        for (int i = 0; i < 40; i++) begin step(); if (B_ACK) break; end
        B_ADDR = 29'h301; B_DIN = 64'hB1;
        for (int i = 0; i < 40; i++) begin step(); if (B_ACK) break; end
        B_REQ = 1'b0;
      end
    join
    for (int i = 0; i < 40 && cmd_q.size() < 5; i++) step();
    repeat (4) step();
    ea[0] = 29'h300; ed[0] = 64'hB0;
    ea[1] = 29'h200; ed[1] = 64'hA0;
    ea[2] = 29'h301; ed[2] = 64'hB1;
    ea[3] = 29'h201; ed[3] = 64'hA1;
    ea[4] = 29'h202; ed[4] = 64'hA2;
    n_checks++; if (cmd_q.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", cmd_q.size()); end
    for (int i = 0; i < cmd_q.size() && i < 5; i++) begin
      n_checks++;
      if (cmd_q[i].we !== 1'b1 || cmd_q[i].addr !== ea[i] || cmd_q[i].din !== ed[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got we=%b %h/%h expected 1 %h/%h", i, cmd_q[i].we, cmd_q[i].addr, cmd_q[i].din, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_high_wm();
    logic [28:0] ea [8];
    cmd_q.delete();
    DDRAM_BUSY = 1'b1;
    A_WE = 1'b1; A_BE = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      A_ADDR = 29'h410 + 29'(i);
      A_DIN  = 64'h4100 + 64'(i);
      step();
    end
    A_WE = 1'b0;
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 29'h4B0; B_DIN = 64'hBB; B_BE = 8'h0F;
    repeat (2) step();
    n_checks++; if (A_FULL !== 1'b0) begin n_fail++; $display("FAIL wm_full_at7: got %b expected 0", A_FULL); end
    DDRAM_BUSY = 1'b0;
    for (int i = 0; i < 60; i++) begin step(); if (B_ACK) break; end
    B_REQ = 1'b0;
    for (int i = 0; i < 60 && cmd_q.size() < 8; i++) step();
    repeat (4) step();
    ea[0] = 29'h410; ea[1] = 29'h411; ea[2] = 29'h4B0; ea[3] = 29'h412;
    ea[4] = 29'h413; ea[5] = 29'h414; ea[6] = 29'h415; ea[7] = 29'h416;
    n_checks++; if (cmd_q.size() != 8) begin n_fail++; $display("FAIL wm_count: got %0d expected 8", cmd_q.size()); end
    for (int i = 0; i < cmd_q.size() && i < 8; i++) begin
      n_checks++;
      if (cmd_q[i].addr !== ea[i]) begin n_fail++; $display("FAIL wm_order[%0d]: got %h expected %h", i, cmd_q[i].addr, ea[i]); end
    end
  endtask

  task automatic test_busy_hold();
    int bad = 0;
    int held = 0;
    cmd_q.delete();
    DDRAM_BUSY = 1'b1;
    A_WE = 1'b1; A_BE = 8'hC3;
    for (int i = 0; i < 9; i++) begin
      A_ADDR = 29'h500 + 29'(i);
      A_DIN  = 64'h5555_0000_0000_0000 + 64'(i);
      step();
      if (i >= 1) begin
        held++;
        if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'h500 || DDRAM_DIN !== 64'h5555_0000_0000_0000 || DDRAM_BE !== 8'hC3) bad++;
      end
    end
    A_WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      held++;
      if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'h500 || DDRAM_DIN !== 64'h5555_0000_0000_0000 || DDRAM_BE !== 8'hC3) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable of %0d cycles expected 0", bad, held); end
    n_checks++; if (A_FULL !== 1'b1) begin n_fail++; $display("FAIL hold_full: got %b expected 1", A_FULL); end
    n_checks++; if (A_OVF !== 1'b1) begin n_fail++; $display("FAIL hold_ovf: got %b expected 1", A_OVF); end
    n_checks++; if (cmd_q.size() != 0) begin n_fail++; $display("FAIL hold_no_accept: got %0d expected 0", cmd_q.size()); end
    DDRAM_BUSY = 1'b0;
    for (int i = 0; i < 60 && cmd_q.size() < 8; i++) step();
    repeat (6) step();
    n_checks++; if (cmd_q.size() != 8) begin n_fail++; $display("FAIL hold_count: got %0d expected 8", cmd_q.size()); end
    for (int i = 0; i < cmd_q.size() && i < 8; i++) begin
      n_checks++;
      if (cmd_q[i].addr !== 29'h500 + 29'(i) || cmd_q[i].din !== 64'h5555_0000_0000_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL hold_order[%0d]: got %h/%h expected %h", i, cmd_q[i].addr, cmd_q[i].din, 29'h500 + 29'(i));
      end
    end
    n_checks++; if (A_FULL !== 1'b0) begin n_fail++; $display("FAIL hold_drain_full: got %b expected 0", A_FULL); end
  endtask

  task automatic test_reset_mid_read();
    cmd_q.delete();
    ack_cnt = 0;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 29'h600;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_q.size() > 0) break;
    end
    step();
    reset = 1'b1;
    B_REQ = 1'b0;
    step();
    reset = 1'b0;
    n_checks++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cmd: got we=%b rd=%b expected 0/0", DDRAM_WE, DDRAM_RD); end
    step();
    DDRAM_DOUT_READY = 1'b1;
    DDRAM_DOUT = 64'h1234_5678_9ABC_DEF0;
    step();
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT = 64'h0;
    repeat (4) step();
    n_checks++; if (ack_cnt != 0) begin n_fail++; $display("FAIL mid_rst_ack: got %0d expected 0", ack_cnt); end
    n_checks++; if (B_DOUT !== 64'h0) begin n_fail++; $display("FAIL mid_rst_dout: got %h expected 0", B_DOUT); end
    n_checks++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL mid_rst_cmds: got %0d expected 1", cmd_q.size()); end
    n_checks++; if (A_OVF !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf: got %b expected 0", A_OVF); end
    A_WE = 1'b1; A_ADDR = 29'h700; A_DIN = 64'h77; A_BE = 8'h81;
    step();
    A_WE = 1'b0;
    step();
    n_checks++; if (DDRAM_WE !== 1'b1 || DDRAM_ADDR !== 29'h700) begin n_fail++; $display("FAIL mid_rst_idle: got we=%b addr=%h expected 1 700", DDRAM_WE, DDRAM_ADDR); end
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_a_writes();
    test_b_read();
    test_round_robin();
    test_high_wm();
    test_busy_hold();
    test_reset_mid_read();
    n_checks++; if (both_seen) begin n_fail++; $display("FAIL we_rd_exclusive: got both asserted expected never"); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fb_ddram_arbiter.md
Name: fb_ddram_arbiter

Overview:
- Shares one DDRAM port between two requesters:
  - Port A: the screen-rotation pixel writer, posted writes with no back-pressure, buffered in a small FIFO.
  - Port B: a generic client (loader, debug reader) doing single-beat reads and writes through a req/ack handshake.
- Sits between the rotation block and the sys DDRAM interface.
- Schedules by FIFO watermark plus round-robin.

Parameters:
- FIFO_DEPTH, 8, port-A write FIFO entries; power of two, 4..32.
- HIGH_WM, 6, FIFO level at or above which port A has absolute priority.

Ports:
- CLK_VIDEO  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- A_WE  in  1  one-cycle write strobe from the rotator.
- A_ADDR  in  29  port-A write address (64-bit word).
- A_DIN  in  64  port-A write data.
- A_BE  in  8  port-A byte enables.
- A_FULL  out  1  FIFO level == FIFO_DEPTH.
- A_OVF  out  1  sticky overflow flag; cleared by reset.
- B_REQ  in  1  port-B request level; held until B_ACK.
- B_WE  in  1  1 = write, 0 = read; sampled with B_REQ.
- B_ADDR  in  29  port-B address.
- B_DIN  in  64  port-B write data.
- B_BE  in  8  port-B byte enables.
- B_DOUT  out  64  port-B read data; valid on B_ACK for reads.
- B_ACK  out  1  one-cycle completion pulse.
- DDRAM_BUSY  in  1  DDRAM stall.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  command address.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.
- DDRAM_RD  out  1  read command.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.

Behaviour:
- Reset values: FIFO empty, A_FULL=0, A_OVF=0, B_ACK=0, B_DOUT=0, DDRAM_WE=0, DDRAM_RD=0, state IDLE, rr_last=B.
- DDRAM command rule:
  - A command is accepted on a rising edge where it is asserted and DDRAM_BUSY=0.
  - While BUSY=1, the command and its ADDR/DIN/BE are held stable.
  - WE and RD are never asserted together.
- FIFO:
  - A_WE pushes {A_ADDR, A_BE, A_DIN} in the same cycle.
  - A push while full is dropped, sets A_OVF, and leaves the FIFO unchanged.
  - A simultaneous push and pop while full is accepted; level stays at FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH; level is a log2(DEPTH)+1-bit counter.
- States:
  - IDLE:
    - Choose A if level >= HIGH_WM.
    - Otherwise, if both A (level > 0) and B_REQ are pending, choose the side not in rr_last.
    - Otherwise choose whichever side is pending.
    - The choice registers the command; next state is WR_A, WR_B or RD_B.
  - WR_A: DDRAM_WE=1 with the FIFO head. On accept: pop, rr_last=A, go to IDLE.
  - WR_B: DDRAM_WE=1 with port-B fields. On accept: B_ACK=1 for one cycle, rr_last=B, go to IDLE.
  - RD_B: DDRAM_RD=1. On accept: go to RD_WAIT.
  - RD_WAIT:
    - On DDRAM_DOUT_READY: B_DOUT<=DDRAM_DOUT, B_ACK=1, rr_last=B, go to IDLE.
    - Port-A pushes continue into the FIFO in this state; no command is issued.
- Latency: minimum 2 cycles from IDLE to command, 1 command per 2 cycles maximum throughput; no back-to-back issue.
- B_REQ must stay high until B_ACK. A B_REQ drop before grant is ignored; a drop after grant does not abort the transfer.
- Mid-operation reset: an outstanding read is abandoned and any later DDRAM_DOUT_READY in IDLE is ignored. DDRAM_WE/RD deassert in the cycle after reset.

Optional Feature:
- FB_ARB_STATS_EN defined: adds output A_DROPS [15:0], a count of dropped port-A pushes; it saturates at 16'hFFFF and resets to 0.
- FB_ARB_STATS_EN also adds output MAX_LEVEL [5:0], the peak FIFO level since reset.
- Without the macro: neither port exists and no logic is generated; A_OVF remains.

Test Plan:
- Reset, then 3 A_WE pushes, BUSY=0 -> three DDRAM_WE accepts in push order with matching ADDR/DIN/BE; level returns to 0; A_OVF=0.
- B read at addr 0x100, BUSY=0, DOUT_READY 5 cycles after RD accept with data 0xDEADBEEF_00C0FFEE -> one-cycle RD, B_ACK with B_DOUT=0xDEADBEEF_00C0FFEE, then idle.
- Level 2 with B_REQ write pending and rr_last=A -> B granted first; next grant is A; grants alternate A/B while both stay pending.
- 6 pushes while BUSY=1 plus B_REQ pending -> after BUSY falls, A is served until level <6 before B is granted.
- BUSY=1 held 10 cycles during WR_A with 9 pushes at FIFO_DEPTH=8 -> command fields stable throughout; A_FULL=1; A_OVF=1; exactly 8 writes emitted afterwards.
- Reset asserted during RD_WAIT, DOUT_READY 2 cycles later -> no B_ACK; state IDLE; no DDRAM command.
